// File: rtl/fifo_prog.sv
// ============================================================================
// Module   : fifo_prog
// Brief    : Single-clock first-word-fall-through FIFO. It supports any depth and has
//            programmable almost-full/empty flags, a fill level and sticky error flags.
//            Optional high-watermark register, enabled by macro FIFO_PROG_WATERMARK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_prog #(
    parameter int NUM_SLOTS     = 6,
    parameter int LOG_NUM_SLOTS = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int AF_THRESHOLD  = 5,
    parameter int AE_THRESHOLD  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_write,
    input  logic                     write,
    output logic                     full,
    output logic                     almost_full,
    output logic [DATA_WIDTH-1:0]    data_read,
    input  logic                     next_read,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [LOG_NUM_SLOTS:0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_errors,
    output logic [LOG_NUM_SLOTS:0]   max_level
);

    localparam int c_lw = LOG_NUM_SLOTS + 1;
    localparam logic [LOG_NUM_SLOTS-1:0] c_last_ptr = LOG_NUM_SLOTS'(NUM_SLOTS - 1);
    localparam logic [LOG_NUM_SLOTS-1:0] c_ptr_one  = LOG_NUM_SLOTS'(1);
    localparam logic [c_lw-1:0]          c_lvl_one  = c_lw'(1);
    localparam logic [c_lw-1:0]          c_full_lvl = c_lw'(NUM_SLOTS);
    localparam logic [c_lw-1:0]          c_af_lvl   = c_lw'(AF_THRESHOLD);
    localparam logic [c_lw-1:0]          c_ae_lvl   = c_lw'(AE_THRESHOLD);

    if (NUM_SLOTS < 2) begin : g_bad_depth
        $error("fifo_prog: NUM_SLOTS must be >= 2");
    end
    if (AF_THRESHOLD < 1 || AF_THRESHOLD > NUM_SLOTS) begin : g_bad_af
        $error("fifo_prog: AF_THRESHOLD out of range 1..NUM_SLOTS");
    end
    if (AE_THRESHOLD < 0 || AE_THRESHOLD > NUM_SLOTS - 1) begin : g_bad_ae
        $error("fifo_prog: AE_THRESHOLD out of range 0..NUM_SLOTS-1");
    end

    logic [DATA_WIDTH-1:0]    r_mem [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] r_rd_ptr;
    logic [LOG_NUM_SLOTS-1:0] r_wr_ptr;
    logic [c_lw-1:0]          r_level;
    logic                     r_overflow;
    logic                     r_underflow;
    logic                     w_push_ok;
    logic                     w_pop_ok;
    logic [c_lw-1:0]          w_level_nxt;

    assign full         = (r_level == c_full_lvl);
    assign almost_full  = (r_level >= c_af_lvl);
    assign empty        = (r_level == '0);
    assign almost_empty = (r_level <= c_ae_lvl);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign data_read    = empty ? '0 : r_mem[r_rd_ptr];

    // A pop on a full FIFO frees the slot the push needs; an empty FIFO never bypasses.
    assign w_push_ok = write & (~full | next_read);
    assign w_pop_ok  = next_read & ~empty;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push_ok && !w_pop_ok) begin
            w_level_nxt = r_level + c_lvl_one;
        end else if (!w_push_ok && w_pop_ok) begin
            w_level_nxt = r_level - c_lvl_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
            end
            r_level     <= w_level_nxt;
            // A new error event outranks a coincident clear.
            r_overflow  <= (r_overflow & ~clear_errors) | (write & ~w_push_ok);
            r_underflow <= (r_underflow & ~clear_errors) | (next_read & empty);
        end
    end

`ifdef FIFO_PROG_WATERMARK_EN
    logic [c_lw-1:0] r_max_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_max_level <= '0;
        end else if (clear_errors || (w_level_nxt > r_max_level)) begin
            r_max_level <= w_level_nxt;
        end
    end

    assign max_level = r_max_level;
`else
    assign max_level = '0;
`endif

endmodule

`default_nettype wire

// File: doc/fifo_prog.md
Name: fifo_prog

Overview:
Parametrised successor to the team's basic single-clock FIFO, for buffering between RTLinf pipeline stages.
- Any depth, including non-power-of-two depths.
- Programmable almost-full and almost-empty thresholds.
- Exposes the fill level.
- Sticky overflow/underflow error flags that drop illegal operations safely.
- Head of queue is exposed combinationally (first-word fall-through); next_read pops the head.

Parameters:
- NUM_SLOTS, 6, depth in entries; any value >= 2.
- LOG_NUM_SLOTS, 3, pointer width; ceil(log2(NUM_SLOTS)).
- DATA_WIDTH, 8, entry width in bits.
- AF_THRESHOLD, 5, almost_full asserts when level >= this; range 1..NUM_SLOTS.
- AE_THRESHOLD, 1, almost_empty asserts when level <= this; range 0..NUM_SLOTS-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_write  in  DATA_WIDTH  write data.
- write  in  1  push request.
- full  out  1  level == NUM_SLOTS.
- almost_full  out  1  level >= AF_THRESHOLD.
- data_read  out  DATA_WIDTH  head entry; 0 when empty.
- next_read  in  1  pop request.
- empty  out  1  level == 0.
- almost_empty  out  1  level <= AE_THRESHOLD.
- level  out  LOG_NUM_SLOTS+1  current occupancy.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was ignored.
- clear_errors  in  1  synchronous clear of overflow and underflow.
- max_level  out  LOG_NUM_SLOTS+1  high watermark (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous):
  - read_ptr, write_ptr, level, overflow, underflow, max_level all go to 0.
  - Outputs after reset: empty=1, almost_empty=1, full=0, almost_full=0, data_read=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately; no clock edge is required.
- Status outputs are combinational decodes of level. data_read is combinational from storage[read_ptr].
- Push acceptance (push_ok) = write & (~full | next_read).
  - When full, a simultaneous pop frees a slot, so the write is accepted.
- Pop acceptance (pop_ok) = next_read & ~empty.
  - When empty, a simultaneous write does not bypass: the pop is ignored and the written data becomes the head on the next cycle.
- On push_ok: storage[write_ptr] <= data_write; write_ptr advances.
- On pop_ok: read_ptr advances.
- Pointer wrap: a pointer at NUM_SLOTS-1 wraps to 0. Plain binary overflow is not used, so non-power-of-two depths are correct.
- level update per cycle: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
  - level never exceeds NUM_SLOTS and never goes below 0.
- Latency: data written at edge N is visible on data_read after edge N when it is the head (FIFO previously empty).
- Error flags:
  - write & ~push_ok sets overflow at the edge; the data is dropped and no state changes.
  - next_read & empty sets underflow; the pop is ignored.
  - Flags hold until clear_errors.
  - If clear_errors coincides with a new error event, set wins and the flag stays 1.
- Thresholds are elaborated constants. Values outside their legal ranges are a configuration error; simulation reports it with $error at time 0.

Optional Feature:
Macro FIFO_PROG_WATERMARK_EN.
- Defined: max_level is a register.
  - Updates to the post-update level whenever that value exceeds the current max_level.
  - clear_errors also resets it to the current post-update level.
  - Reset sets it to 0.
- Undefined: max_level is tied to 0 and no watermark logic is synthesised.
- The port exists in both cases.

Test Plan:
Parameters for all scenarios: NUM_SLOTS=6, DATA_WIDTH=8, AF_THRESHOLD=5, AE_THRESHOLD=1.
1. Reset, then push 0x11..0x16 on consecutive cycles.
   - After 5th push: almost_full=1.
   - After 6th push: full=1, level=6, data_read=0x11.
2. From full, assert write=1 with data 0x77 for one cycle, no pop.
   - overflow=1, level=6, contents unchanged.
   - Then pulse clear_errors: overflow=0.
3. From full, write 0x77 and next_read together.
   - level stays 6, full stays 1, head becomes 0x12.
   - Draining yields 0x12..0x16 then 0x77; this wraps both pointers through index 5 to 0.
4. From empty, assert next_read and write 0x5A in the same cycle.
   - underflow=1, level=1, data_read=0x5A next cycle, empty=0, almost_empty=1.
5. Fill to level 4, then drive rst low mid-cycle with no clock edge.
   - Immediately: empty=1, level=0, data_read=0.
   - After release, push 0x99: data_read=0x99.
6. With FIFO_PROG_WATERMARK_EN defined: push 4, pop 3, push 1.
   - max_level=4 while level=2.
   - clear_errors sets max_level=2.
   - Without the macro, max_level=0 throughout.
